// File: rtl/run_ctrl_pkg.sv
// rtl/run_ctrl_pkg.sv - shared types and defaults for the processor run controller
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } run_state_t;

    localparam int               PC_W_DEFAULT       = 8;
    localparam int               INST_W_DEFAULT     = 9;
    localparam logic [8:0]       HALT_INST_DEFAULT  = 9'h1FF;
    localparam int               CNT_W_DEFAULT      = 16;
    localparam logic [15:0]      MAX_CYCLES_DEFAULT = 16'd50000;

endpackage

// File: rtl/run_ctrl_if.sv
// rtl/run_ctrl_if.sv - start/done handshake and core-control bundle of the run controller
interface run_ctrl_if
    import run_ctrl_pkg::*;
#(
    parameter int PC_W   = PC_W_DEFAULT,
    parameter int INST_W = INST_W_DEFAULT,
    parameter int CNT_W  = CNT_W_DEFAULT
);

    logic              start;
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
    logic              pc_clr;
    logic              run_en;
    logic              done;
    logic              timed_out;
    logic [CNT_W-1:0]  cycle_count;

    // master: host pins plus the core's fetch outputs
    modport master (
        output start, inst, pc,
        input  pc_clr, run_en, done, timed_out, cycle_count
    );

    modport slave (
        input  start, inst, pc,
        output pc_clr, run_en, done, timed_out, cycle_count
    );

endinterface

// File: rtl/run_ctrl.sv
// rtl/run_ctrl.sv - run controller: launches the core on start, ends on halt or cycle budget
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int                PC_W       = PC_W_DEFAULT,
    parameter int                INST_W     = INST_W_DEFAULT,
    parameter logic [INST_W-1:0] HALT_INST  = HALT_INST_DEFAULT,
    parameter int                CNT_W      = CNT_W_DEFAULT,
    parameter logic [CNT_W-1:0]  MAX_CYCLES = MAX_CYCLES_DEFAULT
) (
    input  logic      clk,
    input  logic      rst,
    run_ctrl_if.slave bus
);

    run_state_t       r_state;
    run_state_t       w_state_next;
    logic             r_armed;
    logic [CNT_W-1:0] r_cycle_count;
    logic             r_timed_out;
    logic             w_halt;
    logic             w_budget_end;
    logic [PC_W-1:0]  w_pc_unused;

    // pc is reported to the host only; it never steers the controller
    assign w_pc_unused  = bus.pc;

    assign w_halt       = (bus.inst == HALT_INST);
    assign w_budget_end = (r_cycle_count == MAX_CYCLES - CNT_W'(1));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start && r_armed) begin
                    w_state_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                w_state_next = ST_RUN;
            end
            ST_RUN: begin
                if (w_halt || w_budget_end) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!bus.start) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // a start level held across reset or done must be seen low once before it relaunches
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_armed <= 1'b0;
        end else if (w_state_next == ST_CLEAR) begin
            r_armed <= 1'b0;
        end else if ((r_state == ST_IDLE || r_state == ST_DONE) && !bus.start) begin
            r_armed <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cycle_count <= '0;
            r_timed_out   <= 1'b0;
        end else if (r_state == ST_RUN) begin
            r_cycle_count <= r_cycle_count + CNT_W'(1);
            if (w_state_next == ST_DONE) begin
                r_timed_out <= !w_halt;
            end
        end else if (w_state_next == ST_CLEAR || r_state == ST_CLEAR) begin
            r_cycle_count <= '0;
            r_timed_out   <= 1'b0;
        end
    end

    assign bus.pc_clr      = (r_state == ST_CLEAR);
    assign bus.run_en      = (r_state == ST_RUN);
    assign bus.done        = (r_state == ST_DONE);
    assign bus.timed_out   = r_timed_out;
    assign bus.cycle_count = r_cycle_count;

endmodule

// File: doc/run_ctrl.md
# run_ctrl

Run controller answering the top-level `start`/`done` handshake of the single-cycle processor. It holds the core idle after reset, clears the PC and enables execution when `start` is raised, and watches the fetched instruction for the halt encoding. It asserts `done` on halt or on a cycle-budget timeout, and keeps `done` high until `start` is released. It sits in `top` between the external handshake pins and the `mips` core's PC-clear and run-enable inputs.

## Interface
- `PC_W`, 8, PC width, matches core PC.
- `INST_W`, 9, instruction width.
- `HALT_INST`, 9'h1FF, encoding that ends a run.
- `CNT_W`, 16, cycle-counter width.
- `MAX_CYCLES`, 16'd50000, run cycles before forced completion; legal range 1 to 2^CNT_W−1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `start`  in  1  level request from host; run begins on an armed high level.
- `inst`  in  INST_W  instruction currently fetched by the core.
- `pc`  in  PC_W  current core PC; status only, no control use.
- `pc_clr`  out  1  one-cycle PC clear to the core.
- `run_en`  out  1  core state-update enable (PC, register file, memory writes).
- `done`  out  1  run complete; held until `start` is low.
- `timed_out`  out  1  qualifies `done`: the run ended on the budget, not on halt.
- `cycle_count`  out  CNT_W  RUN cycles of the last or current run.

## Operation
States: IDLE, CLEAR, RUN, DONE. All outputs are decoded from registered state.

- **Reset (`rst`=0 at a clock edge):**
  - state←IDLE, `armed`←0.
  - `pc_clr`=0, `run_en`=0, `done`=0, `timed_out`=0, `cycle_count`=0.
  - Reset applies from any state, including mid-RUN; the core is frozen the next cycle.
- **`armed` flag:** set whenever `start`=0 is sampled in IDLE or DONE. Cleared on entering CLEAR. A `start` held high across reset or across `done` therefore cannot relaunch a run.
  - Exception: the first run after reset is armed when `start`=0 is sampled on the first post-reset edge. A host that raises `start` only after releasing reset must work.
- **IDLE:** `start`=1 with `armed`=1 → CLEAR.
- **CLEAR (exactly 1 cycle):**
  - `pc_clr`=1, `run_en`=0.
  - `cycle_count`←0, `timed_out`←0.
  - → RUN.
- **RUN:**
  - `run_en`=1; `cycle_count`←`cycle_count`+1 every cycle.
  - `inst`==`HALT_INST` → DONE with `timed_out`←0. The halt cycle itself is counted and has `run_en`=1; the core treats HALT as a no-op.
  - Otherwise, if `cycle_count`==`MAX_CYCLES`−1 → DONE with `timed_out`←1.
  - Halt and timeout in the same cycle: halt wins, `timed_out`=0.
  - `start` is ignored in RUN. There is no abort.
- **DONE:**
  - `done`=1, `run_en`=0.
  - `cycle_count` and `timed_out` hold.
  - `start`=0 → IDLE (sets `armed`).
  - If `start` fell during RUN, `done` is high for exactly one cycle.
- `cycle_count` never wraps, because `MAX_CYCLES` < 2^CNT_W.

## Timing
- `start` sampled high at edge t (armed, IDLE): `pc_clr`=1 during t+1; `run_en`=1 from t+2. The first instruction executes at PC 0 in cycle t+2.
- `inst`==`HALT_INST` during RUN cycle k: `done`=1 and `run_en`=0 from k+1.
- For a program whose halt sits at its Nth executed instruction, `cycle_count`=N.
- `start` sampled low at edge d in DONE: `done`=0 from d+1.
- Earliest relaunch is then one cycle later: `start`=1 at d+1 gives CLEAR at d+2.
- Reset is synchronous only; asserting `rst` has no effect until the next `clk` edge.

## Structure
- Shared package `run_ctrl_pkg` holds:
  - the state enum `run_state_t` (IDLE, CLEAR, RUN, DONE);
  - `HALT_INST_DEFAULT`;
  - `CNT_W_DEFAULT`.
  - `top` and the core decoder import `HALT_INST_DEFAULT` so the halt encoding lives in one place.
- No sub-module. The state register, the `armed` flag and the counter are inline.
- `top` drives its existing `rst` pin straight into this block. The core's PC register takes `pc_clr | ~rst`.

## Test plan
- **Halt run:** reset 2 cycles; `start`=1; program halts at its 5th instruction → `pc_clr` one cycle, `done`=1 exactly 7 cycles after `start` is sampled, `cycle_count`=5, `timed_out`=0.
- **Timeout:** `MAX_CYCLES`=10, program with no halt → `done`=1 at RUN cycle 11, `timed_out`=1, `cycle_count`=10, `run_en`=0 thereafter.
- **Halt on the final budget cycle:** `MAX_CYCLES`=10, halt at instruction 10 → `timed_out`=0, `cycle_count`=10.
- **Held start:** `start` kept high after `done` → no relaunch, `done` stays 1. Drop `start` → `done`=0 next cycle. Raise `start` again → new CLEAR, `cycle_count` reset to 0.
- **Reset mid-run:** `rst`=0 at RUN cycle 3 → next edge: `run_en`=0, `cycle_count`=0, `done`=0. After release, `start` held high does not restart until it is seen low once.
- **Start dropped during RUN:** release `start` at RUN cycle 2 → run completes, `done` is high for exactly one cycle, then IDLE.
